// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared codes for the M-stage memory access unit.
//   - DMEXT_* : width codes shared with the load-extension stage; stores
//               use the same encoding.
//   - mau_state_e : access FSM states.
//   - mau_exc_e   : exception codes reported on exc_code.
package mem_access_unit_pkg;

   // Width select codes shared with the extension stage.
   localparam logic [2:0] DMEXT_LW = 3'd0;
   localparam logic [2:0] DMEXT_LH = 3'd1;
   localparam logic [2:0] DMEXT_LB = 3'd2;

   typedef enum logic [1:0] {
      MAU_IDLE = 2'd0,
      MAU_REQ  = 2'd1,
      MAU_DONE = 2'd2
   } mau_state_e;

   typedef enum logic [1:0] {
      MAU_EXC_LD_MISALIGN = 2'd0,
      MAU_EXC_ST_MISALIGN = 2'd1,
      MAU_EXC_BUS_TIMEOUT = 2'd2,
      MAU_EXC_ILLEGAL_SEL = 2'd3
   } mau_exc_e;

   localparam int NUM_LANES = 4;

endpackage

// File: rtl/mau_bus_if.sv
// mau_bus_if
//   Word-aligned data-memory bus between the access unit (master) and
//   the memory (slave).
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata : master -> slave
//   bus_ack/bus_rdata                        : slave -> master
interface mau_bus_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mau_lane_gen.sv
// mau_lane_gen
//   Combinational byte-lane generation for one access.
//   sel      : width code (DMEXT_*)
//   addr_lo  : byte offset within the word
//   wdata    : right-justified store data
//   be       : byte enables for the word-aligned bus
//   lane_wd  : store data replicated into every lane it may land in
//   misalign : W not on a word boundary, or H on an odd byte
//   illegal  : sel is not one of W/H/B
module mau_lane_gen
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  sel,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] lane_wd,
   output logic        misalign,
   output logic        illegal
);

   logic is_w, is_h, is_b;
   logic [NUM_LANES-1:0][7:0] wd_lanes;

   assign is_w = (sel == DMEXT_LW);
   assign is_h = (sel == DMEXT_LH);
   assign is_b = (sel == DMEXT_LB);

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LN = 2'(i);
      // Halfwords pick their half by addr[1]; bytes pick their lane exactly.
      assign be[i] = is_w
                   | (is_h && (addr_lo[1] == LN[1]))
                   | (is_b && (addr_lo == LN));
      // Replicate so the slave can take whichever lane the enable selects.
      assign wd_lanes[i] = is_w ? wdata[8*i +: 8]
                         : is_h ? wdata[8*(i%2) +: 8]
                         :        wdata[7:0];
   end

   assign lane_wd  = wd_lanes;
   assign misalign = (is_w && (addr_lo != 2'b00)) || (is_h && addr_lo[0]);
   assign illegal  = !(is_w || is_h || is_b);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   M-stage data-memory access controller. Checks alignment, issues one
//   word-aligned bus transaction per memory instruction, stalls the
//   pipeline until the ack (or a timeout), and hands the raw read word,
//   low address bits and width to the load-extension stage.
//   clk, reset      : clock, synchronous active-low reset
//   m_valid/m_we/m_sel/m_addr/m_wdata : request from the M stage
//   stall           : freeze F/D/E/M
//   bus             : memory bus (master side)
//   rd_valid/rd_word/rd_addr_lo/rd_sel : load result to extension stage
//   exc/exc_code    : one-cycle exception pulse and its cause
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m_valid,
   input  logic        m_we,
   input  logic [2:0]  m_sel,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   output logic        stall,
   mau_bus_if.master   bus,
   output logic        rd_valid,
   output logic [31:0] rd_word,
   output logic [1:0]  rd_addr_lo,
   output logic [2:0]  rd_sel,
   output logic        exc,
   output logic [1:0]  exc_code
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   mau_state_e  state, state_nxt;
   logic [7:0]  cnt;
   logic [3:0]  be;
   logic [31:0] lane_wd;
   logic        misalign, illegal;
   logic        in_req;
   logic        chk_err, take_ack, take_to;

   mau_lane_gen u_lane_gen (
      .sel      (m_sel),
      .addr_lo  (m_addr[1:0]),
      .wdata    (m_wdata),
      .be       (be),
      .lane_wd  (lane_wd),
      .misalign (misalign),
      .illegal  (illegal)
   );

   // Bus signals follow the held M-stage inputs while the request is open.
   assign in_req        = (state == MAU_REQ);
   assign bus.bus_req   = in_req;
   assign bus.bus_we    = in_req & m_we;
   assign bus.bus_addr  = in_req ? {m_addr[31:2], 2'b00} : 32'h0;
   assign bus.bus_be    = in_req ? be : 4'h0;
   assign bus.bus_wdata = in_req ? lane_wd : 32'h0;

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      chk_err   = 1'b0;
      take_ack  = 1'b0;
      take_to   = 1'b0;
      case (state)
         MAU_IDLE: begin
            if (m_valid) begin
               if (misalign || illegal) begin
                  chk_err = 1'b1;
               end else begin
                  stall     = 1'b1;
                  state_nxt = MAU_REQ;
               end
            end
         end
         MAU_REQ: begin
            stall = 1'b1;
            // An ack on the final cycle beats the timeout.
            if (bus.bus_ack) begin
               take_ack  = 1'b1;
               state_nxt = MAU_DONE;
            end else if (cnt == CNT_LAST) begin
               take_to   = 1'b1;
               state_nxt = MAU_DONE;
            end
         end
         MAU_DONE: begin
            // m_valid is ignored here: the pipeline advances at this edge,
            // so the same instruction must not be re-issued.
            state_nxt = MAU_IDLE;
         end
         default: state_nxt = MAU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= MAU_IDLE;
         cnt        <= 8'h0;
         rd_valid   <= 1'b0;
         rd_word    <= 32'h0;
         rd_addr_lo <= 2'b00;
         rd_sel     <= 3'b000;
         exc        <= 1'b0;
         exc_code   <= 2'b00;
      end else begin
         state    <= state_nxt;
         rd_valid <= 1'b0;
         exc      <= 1'b0;
         cnt      <= (in_req && state_nxt == MAU_REQ) ? cnt + 8'h1 : 8'h0;

         if (chk_err) begin
            exc <= 1'b1;
            if (illegal)   exc_code <= MAU_EXC_ILLEGAL_SEL;
            else if (m_we) exc_code <= MAU_EXC_ST_MISALIGN;
            else           exc_code <= MAU_EXC_LD_MISALIGN;
         end

         if (take_ack || take_to) begin
            rd_word    <= take_ack ? bus.bus_rdata : 32'h0;
            rd_addr_lo <= m_addr[1:0];
            rd_sel     <= m_sel;
            rd_valid   <= !m_we;
         end

         if (take_to) begin
            exc      <= 1'b1;
            exc_code <= MAU_EXC_BUS_TIMEOUT;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_valid, m_we;
   logic [2:0]  m_sel;
   logic [31:0] m_addr, m_wdata;
   logic        stall, rd_valid, exc;
   logic [31:0] rd_word;
   logic [1:0]  rd_addr_lo, exc_code;
   logic [2:0]  rd_sel;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   mau_bus_if bus_i ();

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .m_valid    (m_valid),
      .m_we       (m_we),
      .m_sel      (m_sel),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .stall      (stall),
      .bus        (bus_i),
      .rd_valid   (rd_valid),
      .rd_word    (rd_word),
      .rd_addr_lo (rd_addr_lo),
      .rd_sel     (rd_sel),
      .exc        (exc),
      .exc_code   (exc_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [2:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_at;   // REQ cycle index carrying the ack; 99 = never
      bit          err;
      logic [1:0]  code;
      logic [3:0]  be;
      logic [31:0] bwd;
      int          nreq;
      bit          to;
   } vec_t;

   vec_t vec[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic run_vec(input int k, input vec_t v);
      int n;
      string t;
      t = $sformatf("v%0d", k);
      @(negedge clk);
      m_valid = 1'b1; m_we = v.we; m_sel = v.sel; m_addr = v.addr; m_wdata = v.wdata;
      bus_i.bus_ack = 1'b0; bus_i.bus_rdata = 32'h0;
      #1;
      chk({t, " accept_req"}, 32'(bus_i.bus_req), 32'd0);
      if (v.err) begin
         chk({t, " err_stall"}, 32'(stall), 32'd0);
         @(negedge clk); m_valid = 1'b0; #1;
         chk({t, " exc"}, 32'(exc), 32'd1);
         chk({t, " exc_code"}, 32'(exc_code), 32'(v.code));
         chk({t, " no_bus"}, 32'(bus_i.bus_req), 32'd0);
         @(negedge clk); #1;
         chk({t, " exc_pulse"}, 32'(exc), 32'd0);
      end else begin
         chk({t, " accept_stall"}, 32'(stall), 32'd1);
         n = 0;
         for (int c = 0; c < TO + 1; c++) begin
            @(negedge clk);
            bus_i.bus_ack = (c == v.ack_at);
            bus_i.bus_rdata = v.rdata;
            #1;
            if (bus_i.bus_req === 1'b1 && stall === 1'b1) n++;
            if (c == 0) begin
               chk({t, " be"}, 32'(bus_i.bus_be), 32'(v.be));
               chk({t, " wdata"}, bus_i.bus_wdata, v.bwd);
               chk({t, " addr"}, bus_i.bus_addr, {v.addr[31:2], 2'b00});
               chk({t, " we"}, 32'(bus_i.bus_we), 32'(v.we));
            end
            if (c == v.ack_at || c == TO - 1) break;
         end
         chk({t, " req_cycles"}, 32'(n), 32'(v.nreq));
         @(negedge clk);
         m_valid = 1'b0; bus_i.bus_ack = 1'b0;
         #1;
         chk({t, " done_stall"}, 32'(stall), 32'd0);
         chk({t, " done_req"}, 32'(bus_i.bus_req), 32'd0);
         chk({t, " rd_valid"}, 32'(rd_valid), 32'(!v.we));
         chk({t, " exc"}, 32'(exc), 32'(v.to));
         if (v.to) chk({t, " exc_code"}, 32'(exc_code), 32'(MAU_EXC_BUS_TIMEOUT));
         if (!v.we) begin
            chk({t, " rd_word"}, rd_word, v.to ? 32'h0 : v.rdata);
            chk({t, " rd_addr_lo"}, 32'(rd_addr_lo), 32'(v.addr[1:0]));
            chk({t, " rd_sel"}, 32'(rd_sel), 32'(v.sel));
         end
         @(negedge clk); #1;
         chk({t, " idle_rd_valid"}, 32'(rd_valid), 32'd0);
         chk({t, " idle_exc"}, 32'(exc), 32'd0);
         if (!v.we) chk({t, " hold_word"}, rd_word, v.to ? 32'h0 : v.rdata);
      end
   endtask

   initial begin
      int nreq;
      //            we sel       addr          wdata         rdata         ack err code be     bwd           nreq to
      vec[0]  = '{0, DMEXT_LW, 32'h100, 32'h0,        32'hDEADBEEF, 0,  0, 2'd0, 4'b1111, 32'h0,        1, 0};
      vec[1]  = '{1, DMEXT_LB, 32'h103, 32'h000000A5, 32'h0,        2,  0, 2'd0, 4'b1000, 32'hA5A5A5A5, 3, 0};
      vec[2]  = '{0, DMEXT_LH, 32'h101, 32'h0,        32'h0,        0,  1, 2'd0, 4'b0000, 32'h0,        0, 0};
      vec[3]  = '{1, DMEXT_LW, 32'h102, 32'h0,        32'h0,        0,  1, 2'd1, 4'b0000, 32'h0,        0, 0};
      vec[4]  = '{0, DMEXT_LB, 32'h002, 32'h0,        32'h12345678, 99, 0, 2'd0, 4'b0100, 32'h0,        4, 1};
      vec[5]  = '{0, 3'd5,     32'h000, 32'h0,        32'h0,        0,  1, 2'd3, 4'b0000, 32'h0,        0, 0};
      vec[6]  = '{0, DMEXT_LH, 32'h102, 32'h0,        32'h8001CAFE, 1,  0, 2'd0, 4'b1100, 32'h0,        2, 0};
      vec[7]  = '{1, DMEXT_LH, 32'h200, 32'hFFFF1234, 32'h0,        0,  0, 2'd0, 4'b0011, 32'h12341234, 1, 0};
      vec[8]  = '{1, DMEXT_LW, 32'h3FC, 32'h11223344, 32'h0,        0,  0, 2'd0, 4'b1111, 32'h11223344, 1, 0};
      vec[9]  = '{0, DMEXT_LW, 32'h500, 32'h0,        32'h0BADF00D, 3,  0, 2'd0, 4'b1111, 32'h0,        4, 0};
      vec[10] = '{0, DMEXT_LB, 32'h001, 32'h0,        32'h000000C3, 0,  0, 2'd0, 4'b0010, 32'h0,        1, 0};

      reset = 1'b0; m_valid = 1'b0; m_we = 1'b0; m_sel = 3'd0; m_addr = 32'h0; m_wdata = 32'h0;
      bus_i.bus_ack = 1'b0; bus_i.bus_rdata = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_req", 32'(bus_i.bus_req), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_word", rd_word, 32'h0);
      chk("rst_exc", 32'(exc), 32'd0);
      chk("rst_meta", {25'h0, rd_sel, rd_addr_lo, exc_code}, 32'h0);

      for (int k = 0; k < 11; k++) run_vec(k, vec[k]);

      // Reset in the second REQ cycle of SH 0x202 abandons the access.
      @(negedge clk);
      m_valid = 1'b1; m_we = 1'b1; m_sel = DMEXT_LH; m_addr = 32'h202; m_wdata = 32'h1234;
      #1;
      chk("sh_accept_stall", 32'(stall), 32'd1);
      @(negedge clk); #1;
      chk("sh_req1", 32'(bus_i.bus_req), 32'd1);
      chk("sh_be", 32'(bus_i.bus_be), 32'hC);
      chk("sh_wdata", bus_i.bus_wdata, 32'h12341234);
      @(negedge clk); reset = 1'b0; #1;
      chk("sh_req2", 32'(bus_i.bus_req), 32'd1);
      @(negedge clk); reset = 1'b1; m_valid = 1'b0; #1;
      chk("rst2_req", 32'(bus_i.bus_req), 32'd0);
      chk("rst2_stall", 32'(stall), 32'd0);
      chk("rst2_rd_word", rd_word, 32'h0);
      chk("rst2_flags", {28'h0, rd_valid, exc, exc_code}, 32'h0);
      chk("rst2_meta", {27'h0, rd_sel, rd_addr_lo}, 32'h0);
      @(negedge clk); bus_i.bus_ack = 1'b1; bus_i.bus_rdata = 32'hFFFFFFFF; #1;
      @(negedge clk); bus_i.bus_ack = 1'b0; #1;
      chk("late_ack_valid", 32'(rd_valid), 32'd0);
      chk("late_ack_word", rd_word, 32'h0);
      chk("late_ack_req", 32'(bus_i.bus_req), 32'd0);

      // Back-to-back loads with m_valid held high.
      nreq = 0;
      @(negedge clk);
      m_valid = 1'b1; m_we = 1'b0; m_sel = DMEXT_LW; m_addr = 32'h400;
      #1;
      chk("b2b_s0", 32'(stall), 32'd1);
      @(negedge clk); bus_i.bus_ack = 1'b1; bus_i.bus_rdata = 32'h11111111; #1;
      if (bus_i.bus_req === 1'b1) nreq++;
      chk("b2b_s1", 32'(stall), 32'd1);
      @(negedge clk); bus_i.bus_ack = 1'b0; m_addr = 32'h404; #1;
      if (bus_i.bus_req === 1'b1) nreq++;
      chk("b2b_done1_stall", 32'(stall), 32'd0);
      chk("b2b_rv1", 32'(rd_valid), 32'd1);
      chk("b2b_word1", rd_word, 32'h11111111);
      @(negedge clk); #1;
      if (bus_i.bus_req === 1'b1) nreq++;
      chk("b2b_s3", 32'(stall), 32'd1);
      @(negedge clk); bus_i.bus_ack = 1'b1; bus_i.bus_rdata = 32'h22222222; #1;
      if (bus_i.bus_req === 1'b1) nreq++;
      chk("b2b_addr2", bus_i.bus_addr, 32'h404);
      @(negedge clk); bus_i.bus_ack = 1'b0; m_valid = 1'b0; #1;
      if (bus_i.bus_req === 1'b1) nreq++;
      chk("b2b_rv2", 32'(rd_valid), 32'd1);
      chk("b2b_word2", rd_word, 32'h22222222);
      @(negedge clk); #1;
      if (bus_i.bus_req === 1'b1) nreq++;
      chk("b2b_issues", 32'(nreq), 32'd2);
      chk("b2b_rv_end", 32'(rd_valid), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
